thermo_stream_checker: RTL and testbench
========================================

Name: thermo_stream_checker

Overview:
- Pipelined, parametrised successor to the combinational thermometer-code detector.
- Classifies a stream of DATA_WIDTH-bit code words under a run-time selected code type (two thermometer forms or one-hot) and decodes each word to a level.
- Flags level jumps larger than MAX_STEP between successive legal codes and keeps a saturating error count.
- Sits between an ADC/DAC segment-control bus and the monitoring/status logic.

Parameters:
- DATA_WIDTH, 8, code word width (>=2).
- MAX_STEP, 1, maximum allowed |level change| between successive legal codes.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_mode qualify this cycle.
- in_data  input  DATA_WIDTH  code word.
- in_mode  input  2  code type: 0 = any-polarity thermometer, 1 = one-hot, 2 = LSB-justified thermometer, 3 = reserved.
- clr_cnt  input  1  synchronous clear of err_count and slew history.
- out_valid  output  1  results valid.
- is_legal  output  1  word is legal for its mode.
- level  output  $clog2(DATA_WIDTH+1)  decoded level.
- slew_err  output  1  legal word, level jump > MAX_STEP.
- err_count  output  CNT_WIDTH  number of illegal or slew-error words, saturating.

Behaviour:
- Reset: clk/resetn only; asynchronous active-low reset.
  - All outputs 0.
  - Stage registers 0.
  - History flag (have_prev) 0, prev_level 0.
- No back-pressure. One word accepted per cycle when in_valid=1.
- Latency 2 cycles: out_valid(t+2) = in_valid(t). Fully pipelined, back-to-back words supported.
- Stage 1 (registered): classify and decode in_data per the mode captured with it.
  - Mode 0: legal iff exactly one 0/1 transition across the word, either polarity (e.g. 00001111, 11100000). All-0 and all-1 are illegal. level = popcount.
  - Mode 1: legal iff exactly one bit set. level = set-bit index + 1.
  - Mode 2: legal iff word = (1<<k)-1 for k in 0..DATA_WIDTH, including all-0 and all-1. level = k.
  - Mode 3: always illegal.
  - Illegal word: level = 0.
- Stage 2 (registered):
  - slew_err = is_legal & have_prev & |level - prev_level| > MAX_STEP. Use an unsigned absolute difference at level width.
  - On a legal word: prev_level <= level, have_prev <= 1.
  - Illegal words leave the history unchanged.
  - err_count increments by 1 on a valid word with !is_legal | slew_err. It holds at 2^CNT_WIDTH-1 (no wrap).
- Hold rule: when out_valid=0, is_legal, level and slew_err hold their last values. err_count always holds unless updated.
- clr_cnt in a cycle, including one coinciding with a stage-2 error:
  - err_count <= 0 and have_prev <= 0. Clear wins; that error is not counted.
  - Words already in stage 1 are unaffected.
- in_mode is per-word, sampled with in_data. A mode change takes effect on the next word, with no flush.
- Reset mid-stream discards both stages immediately. out_valid=0 until 2 cycles after the first post-reset in_valid.

Optional Feature:
- Macro THERMO_STICKY_ERR_EN.
- Defined:
  - Adds output sticky_err (1 bit, reset 0).
  - Set on the same edge err_count would increment, even when saturated.
  - Cleared only by clr_cnt or reset; clr_cnt wins over a simultaneous set.
- Undefined: port and logic absent. Behaviour otherwise identical.

Decomposition:
- Package thermo_pkg:
  - Enum code_mode_t (MODE_THERMO_ANY, MODE_ONEHOT, MODE_THERMO_LSB, MODE_RSVD).
  - Function lvl_width(w) returning $clog2(w+1).
  - Localparam for the saturation value.
- Sub-module thermo_classify: purely combinational.
  - Inputs: data, mode.
  - Outputs: legal, level.
  - Instantiated in stage 1 and testable standalone.

Test Plan (DATA_WIDTH=8, MAX_STEP=1, CNT_WIDTH=8):
- Mode 0: 00001111, 11110000, 00000000, 00110011 on consecutive cycles → out_valid 2 cycles later for each. Results in order:
  - is_legal 1,1,0,0.
  - level 4,4,0,0.
  - err_count ends at 2.
- Mode 2: 00000111 then 00011111 → second word is_legal=1, level=5, slew_err=1, err_count=1. Then 00111111 → slew_err=0.
- Mode 1: 00010000 → level=5, legal. Then 00011000 → illegal, history unchanged. Then 00100000 → level=6, slew_err=0.
- Saturation: 300 consecutive mode-3 words → err_count reaches 255 and holds. Then assert clr_cnt in the same cycle as an error reaches stage 2 → err_count=0.
- Reset mid-stream: drop resetn with 2 words in flight → outputs 0 asynchronously, and no out_valid pulse for the discarded words after release. The first legal word after release gives slew_err=0 regardless of its level.
- With THERMO_STICKY_ERR_EN: one illegal word → sticky_err=1 and stays set through 10 legal words. clr_cnt → sticky_err=0.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermometer/one-hot stream checker.
// THERMO_STICKY_ERR_EN (used by thermo_stream_checker) adds a sticky error flag.
package thermo_pkg;

  typedef enum logic [1:0] {
    MODE_THERMO_ANY = 2'd0,
    MODE_ONEHOT     = 2'd1,
    MODE_THERMO_LSB = 2'd2,
    MODE_RSVD       = 2'd3
  } code_mode_t;

  // Width needed to hold a level in 0..w.
  function automatic int lvl_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_CNT_WIDTH = 8;
  localparam logic [DEF_CNT_WIDTH-1:0] ERR_CNT_SAT = '1;

endpackage

// File: rtl/thermo_classify.sv
// Combinational legality check and level decode of one code word for a given code type.
module thermo_classify
  import thermo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int LW = lvl_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  code_mode_t            mode,
  output logic                  legal,
  output logic [LW-1:0]         level
);

  logic [DATA_WIDTH-2:0] edges;
  logic [LW-1:0]         ones;
  logic [LW-1:0]         edgeCount;
  logic [LW-1:0]         oneIdx;
  logic [DATA_WIDTH-1:0] dataPlusOne;
  logic                  lsbForm;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : gEdge
      assign edges[gi] = data[gi] ^ data[gi+1];
    end
  endgenerate

  always_comb begin
    ones      = '0;
    edgeCount = '0;
    oneIdx    = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ones = ones + LW'(data[i]);
      if (data[i]) oneIdx = LW'(i + 1);
    end
    for (int i = 0; i < DATA_WIDTH - 1; i++) begin
      edgeCount = edgeCount + LW'(edges[i]);
    end
  end

  // (1<<k)-1 has no bit in common with its successor; all-ones wraps to zero.
  assign dataPlusOne = data + DATA_WIDTH'(1);
  assign lsbForm     = ~|(data & dataPlusOne);

  always_comb begin
    legal = 1'b0;
    level = '0;
    case (mode)
      MODE_THERMO_ANY: begin
        legal = (edgeCount == LW'(1));
        level = legal ? ones : '0;
      end
      MODE_ONEHOT: begin
        legal = (ones == LW'(1));
        level = legal ? oneIdx : '0;
      end
      MODE_THERMO_LSB: begin
        legal = lsbForm;
        level = legal ? ones : '0;
      end
      default: begin
        legal = 1'b0;
        level = '0;
      end
    endcase
  end

endmodule

// File: rtl/thermo_stream_checker.sv
// Two-stage pipelined code-word checker: classify/decode, then slew check and saturating error count.
// Define THERMO_STICKY_ERR_EN to add the sticky_err output.
module thermo_stream_checker
  import thermo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_STEP   = 1,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               in_valid,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic [1:0]                         in_mode,
  input  logic                               clr_cnt,
  output logic                               out_valid,
  output logic                               is_legal,
  output logic [lvl_width(DATA_WIDTH)-1:0]   level,
  output logic                               slew_err,
  output logic [CNT_WIDTH-1:0]               err_count
`ifdef THERMO_STICKY_ERR_EN
  ,
  output logic                               sticky_err
`endif
);

  localparam int LW = lvl_width(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};

  logic          classLegal;
  logic [LW-1:0] classLevel;

  logic          s1ValidReg;
  logic          s1LegalReg;
  logic [LW-1:0] s1LevelReg;
  logic          havePrevReg;
  logic [LW-1:0] prevLevelReg;

  logic [LW-1:0] levelDiff;
  logic          slewNext;
  logic          errEvent;

  thermo_classify #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uClassify (
    .data  (in_data),
    .mode  (code_mode_t'(in_mode)),
    .legal (classLegal),
    .level (classLevel)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1ValidReg <= 1'b0;
      s1LegalReg <= 1'b0;
      s1LevelReg <= '0;
    end else begin
      s1ValidReg <= in_valid;
      if (in_valid) begin
        s1LegalReg <= classLegal;
        s1LevelReg <= classLevel;
      end
    end
  end

  assign levelDiff = (s1LevelReg >= prevLevelReg) ? (s1LevelReg - prevLevelReg)
                                                  : (prevLevelReg - s1LevelReg);
  assign slewNext  = s1LegalReg & havePrevReg & (int'(levelDiff) > MAX_STEP);
  assign errEvent  = s1ValidReg & (~s1LegalReg | slewNext);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      is_legal     <= 1'b0;
      level        <= '0;
      slew_err     <= 1'b0;
      err_count    <= '0;
      havePrevReg  <= 1'b0;
      prevLevelReg <= '0;
    end else begin
      out_valid <= s1ValidReg;
      if (s1ValidReg) begin
        is_legal <= s1LegalReg;
        level    <= s1LevelReg;
        slew_err <= slewNext;
      end
      // A clear wins over both the history update and a coincident error.
      if (clr_cnt) begin
        err_count   <= '0;
        havePrevReg <= 1'b0;
      end else begin
        if (errEvent && err_count != CNT_SAT) err_count <= err_count + 1'b1;
        if (s1ValidReg && s1LegalReg) begin
          havePrevReg  <= 1'b1;
          prevLevelReg <= s1LevelReg;
        end
      end
    end
  end

`ifdef THERMO_STICKY_ERR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       sticky_err <= 1'b0;
    else if (clr_cnt)  sticky_err <= 1'b0;
    else if (errEvent) sticky_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_thermo_stream_checker.sv
// Directed-vector bench for thermo_stream_checker (DATA_WIDTH=8, MAX_STEP=1, CNT_WIDTH=8).
module tb_thermo_stream_checker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       clr_cnt;
  logic       out_valid;
  logic       is_legal;
  logic [3:0] level;
  logic       slew_err;
  logic [7:0] err_count;
`ifdef THERMO_STICKY_ERR_EN
  logic       sticky_err;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  thermo_stream_checker #(
    .DATA_WIDTH(8),
    .MAX_STEP  (1),
    .CNT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .clr_cnt   (clr_cnt),
    .out_valid (out_valid),
    .is_legal  (is_legal),
    .level     (level),
    .slew_err  (slew_err),
    .err_count (err_count)
`ifdef THERMO_STICKY_ERR_EN
    ,
    .sticky_err(sticky_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic expectOut(input string tag, input logic v, input logic lg, input int lvl,
                           input logic sl, input int cnt);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".is_legal"},  32'(is_legal),  32'(lg));
    check({tag, ".level"},     32'(level),     32'(lvl));
    check({tag, ".slew_err"},  32'(slew_err),  32'(sl));
    check({tag, ".err_count"}, 32'(err_count), 32'(cnt));
  endtask

  // Inputs change on the falling edge; results are read on the falling edge too.
  task automatic push(input logic [7:0] d, input logic [1:0] m);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear();
    in_valid = 1'b0;
    clr_cnt  = 1'b1;
    @(negedge clk);
    clr_cnt  = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = '0;
    clr_cnt  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expectOut("reset", 0, 0, 0, 0, 0);
`ifdef THERMO_STICKY_ERR_EN
    check("reset.sticky", 32'(sticky_err), 32'(0));
`endif
    resetn = 1'b1;
    @(negedge clk);

    // Any-polarity thermometer, back-to-back
    push(8'h0F, 2'd0);
    push(8'hF0, 2'd0);
    expectOut("m0 0F", 1, 1, 4, 0, 0);
    push(8'h00, 2'd0);
    expectOut("m0 F0", 1, 1, 4, 0, 0);
    push(8'h33, 2'd0);
    expectOut("m0 00", 1, 0, 0, 0, 1);
    idle(1);
    expectOut("m0 33", 1, 0, 0, 0, 2);
    idle(1);
    expectOut("m0 hold", 0, 0, 0, 0, 2);
    clear();
    expectOut("clr", 0, 0, 0, 0, 0);

    // LSB-justified thermometer with a slew violation
    push(8'h07, 2'd2);
    push(8'h1F, 2'd2);
    expectOut("m2 07", 1, 1, 3, 0, 0);
    push(8'h3F, 2'd2);
    expectOut("m2 1F", 1, 1, 5, 1, 1);
    idle(1);
    expectOut("m2 3F", 1, 1, 6, 0, 1);
    idle(1);
    expectOut("m2 hold", 0, 1, 6, 0, 1);

    // One-hot; illegal word keeps history at 5; then boundary words
    push(8'h10, 2'd1);
    push(8'h18, 2'd1);
    expectOut("m1 10", 1, 1, 5, 0, 1);
    push(8'h20, 2'd1);
    expectOut("m1 18", 1, 0, 0, 0, 2);
    push(8'hFF, 2'd0);
    expectOut("m1 20", 1, 1, 6, 0, 2);
    push(8'h80, 2'd0);
    expectOut("m0 FF", 1, 0, 0, 0, 3);
    push(8'h00, 2'd2);
    expectOut("m0 80", 1, 1, 1, 1, 4);
    push(8'hFF, 2'd2);
    expectOut("m2 00", 1, 1, 0, 0, 4);
    push(8'h00, 2'd1);
    expectOut("m2 FF", 1, 1, 8, 1, 5);
    idle(1);
    expectOut("m1 00", 1, 0, 0, 0, 6);
    idle(1);

    // Saturation with reserved-mode words
    clear();
    check("sat.start", 32'(err_count), 32'(0));
    for (int i = 0; i < 300; i++) begin
      push(8'h00, 2'd3);
      if (i == 99) check("sat.mid", 32'(err_count), 32'(99));
    end
    idle(2);
    expectOut("sat", 0, 0, 0, 0, 255);
`ifdef THERMO_STICKY_ERR_EN
    check("sat.sticky", 32'(sticky_err), 32'(1));
`endif

    // Clear coinciding with an error in stage 2
    push(8'h00, 2'd3);
    in_valid = 1'b0;
    clr_cnt  = 1'b1;
    @(negedge clk);
    clr_cnt  = 1'b0;
    expectOut("clr+err", 1, 0, 0, 0, 0);
`ifdef THERMO_STICKY_ERR_EN
    check("clr+err.sticky", 32'(sticky_err), 32'(0));
`endif
    push(8'h00, 2'd3);
    idle(1);
    expectOut("post-clr err", 1, 0, 0, 0, 1);

    // Reset with two words in flight
    push(8'h01, 2'd2);
    idle(1);
    expectOut("pre-rst 01", 1, 1, 1, 0, 1);
    push(8'hFF, 2'd2);
    push(8'hFF, 2'd2);
    expectOut("pre-rst FF", 1, 1, 8, 1, 2);
    resetn   = 1'b0;
    in_valid = 1'b0;
    #1;
    expectOut("async rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("post-rst quiet", 32'(out_valid), 32'(0));
    end
    push(8'hFF, 2'd2);
    idle(1);
    expectOut("post-rst FF", 1, 1, 8, 0, 0);
    push(8'h01, 2'd2);
    idle(1);
    expectOut("post-rst 01", 1, 1, 1, 1, 1);

`ifdef THERMO_STICKY_ERR_EN
    clear();
    check("sticky.clr", 32'(sticky_err), 32'(0));
    push(8'h00, 2'd3);
    idle(1);
    check("sticky.set", 32'(sticky_err), 32'(1));
    for (int i = 0; i < 10; i++) push((i % 2 == 1) ? 8'h01 : 8'h00, 2'd2);
    idle(2);
    check("sticky.held", 32'(sticky_err), 32'(1));
    check("sticky.cnt", 32'(err_count), 32'(1));
    clear();
    check("sticky.cleared", 32'(sticky_err), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
